// File: rtl/gpioctrl_pkg.sv
// Shared encodings for the GPIO hardware initiator: command opcodes,
// register offsets and FSM state names.
package gpioctrl_pkg;

    localparam logic CMDCONFIGUREIO = 1'b0;
    localparam logic CMDSETDEBOUNCE = 1'b1;

    // CMD sits one 64-bit slot above DATA, expressed in bus words.
    function automatic int cmd_off(input int archbitsz);
        return 64 / archbitsz;
    endfunction

    typedef enum logic [3:0] {
        ST_INIT_CFGW,
        ST_INIT_CFGR,
        ST_INIT_DBNW,
        ST_INIT_DBNR,
        ST_IDLE,
        ST_XFER_OUT,
        ST_XFER_IN,
        ST_INTACK,
        ST_ERR
    } gpio_state_t;

endpackage

// File: rtl/gpioctrl_xfer.sv
// Single Wishbone transfer engine: strobe held through stall, cycle held
// until ack, ack timeout counted from strobe acceptance.
module gpioctrl_xfer
    import gpioctrl_pkg::*;
#(
    parameter int AW    = 15,
    parameter int DW    = 16,
    parameter int ACKTO = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    output logic            cyc,
    output logic            stb,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW/8-1:0] sel,
    output logic [DW-1:0]   bus_dat,
    input  logic            bsy,
    input  logic            ack,
    input  logic [DW-1:0]   dat,
    output logic            done,
    output logic [DW-1:0]   rdata,
    output logic            timeout
);

    logic [7:0] cnt;

    // Acks only count once the strobe has been accepted.
    assign done    = cyc && !stb && ack;
    assign timeout = cyc && !stb && !ack && (cnt == 8'(ACKTO));
    assign rdata   = dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc      <= 1'b0;
            stb      <= 1'b0;
            bus_we   <= 1'b0;
            bus_addr <= '0;
            sel      <= '0;
            bus_dat  <= '0;
            cnt      <= '0;
        end else if (!cyc) begin
            if (start) begin
                cyc      <= 1'b1;
                stb      <= 1'b1;
                bus_we   <= we;
                bus_addr <= addr;
                sel      <= '1;
                bus_dat  <= wdata;
                cnt      <= '0;
            end
        end else if (stb) begin
            cnt <= '0;
            if (!bsy) stb <= 1'b0;
        end else if (ack || timeout) begin
            cyc <= 1'b0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/gpioctrl.sv
// GPIO hardware initiator: boots the slave, then services interrupts,
// buffered output writes and input polls over Wishbone.
module gpioctrl
    import gpioctrl_pkg::*;
#(
    parameter int ARCHBITSZ  = 16,
    parameter int IOCOUNT    = 1,
    parameter int TMASK      = 0,
    parameter int DBNCTHRESH = 0,
    parameter int CLKFREQ    = 1,
    parameter int BASEADDR   = 0,
    parameter int ACKTO      = 255,
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [ADDRBITSZ-1:0]   wb_addr_o,
    output logic [ARCHBITSZ/8-1:0] wb_sel_o,
    output logic [ARCHBITSZ-1:0]   wb_dat_o,
    input  logic                   wb_bsy_i,
    input  logic                   wb_ack_i,
    input  logic [ARCHBITSZ-1:0]   wb_dat_i,
    input  logic                   intrqst_i,
    output logic                   intrdy_o,
    input  logic [IOCOUNT-1:0]     out_i,
    input  logic                   out_we_i,
    input  logic                   rd_req_i,
    output logic [IOCOUNT-1:0]     in_o,
    output logic                   in_vld_o,
    output logic                   rdy_o,
    output logic                   err_o
);

    localparam int AW = ARCHBITSZ - 1;
    localparam logic [ADDRBITSZ-1:0] DATA_ADDR = ADDRBITSZ'(BASEADDR);
    localparam logic [ADDRBITSZ-1:0] CMD_ADDR  = ADDRBITSZ'(BASEADDR + cmd_off(ARCHBITSZ));
    localparam logic [ARCHBITSZ-1:0] CFG_CMD = {CMDCONFIGUREIO, AW'(TMASK)};
    localparam logic [ARCHBITSZ-1:0] CFG_RSP = {CMDCONFIGUREIO, AW'(IOCOUNT)};
    localparam logic [ARCHBITSZ-1:0] DBN_CMD = {CMDSETDEBOUNCE, AW'(DBNCTHRESH)};
    localparam logic [ARCHBITSZ-1:0] DBN_RSP = {CMDSETDEBOUNCE, AW'(CLKFREQ)};

    gpio_state_t           state;
    logic                  launched, irq_rd, wr_pend, rd_pend;
    logic [IOCOUNT-1:0]    shadow;
    logic [1:0]            hold;
    logic                  start, req_we, done, timeout, fault;
    logic [ADDRBITSZ-1:0]  req_addr;
    logic [ARCHBITSZ-1:0]  req_wdata, rdata;

    always_comb begin
        req_we    = 1'b0;
        req_addr  = CMD_ADDR;
        req_wdata = '0;
        start     = !launched;
        case (state)
            ST_INIT_CFGW: begin req_we = 1'b1; req_wdata = CFG_CMD; end
            ST_INIT_CFGR: ;
            ST_INIT_DBNW: begin req_we = 1'b1; req_wdata = DBN_CMD; end
            ST_INIT_DBNR: ;
            ST_XFER_OUT:  begin req_we = 1'b1; req_addr = DATA_ADDR; req_wdata = ARCHBITSZ'(shadow); end
            ST_XFER_IN:   req_addr = DATA_ADDR;
            default:      start = 1'b0;
        endcase
    end

    assign fault = timeout
                || (done && state == ST_INIT_CFGR && rdata != CFG_RSP)
                || (done && state == ST_INIT_DBNR && rdata != DBN_RSP);

    gpioctrl_xfer #(.AW(ADDRBITSZ), .DW(ARCHBITSZ), .ACKTO(ACKTO)) u_xfer (
        .clk(clk_i), .rst_n(rst_ni), .start(start), .we(req_we), .addr(req_addr),
        .wdata(req_wdata), .cyc(wb_cyc_o), .stb(wb_stb_o), .bus_we(wb_we_o),
        .bus_addr(wb_addr_o), .sel(wb_sel_o), .bus_dat(wb_dat_o), .bsy(wb_bsy_i),
        .ack(wb_ack_i), .dat(wb_dat_i), .done(done), .rdata(rdata), .timeout(timeout)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_INIT_CFGW;
            launched <= 1'b0;
            irq_rd   <= 1'b0;
            wr_pend  <= 1'b0;
            rd_pend  <= 1'b0;
            shadow   <= '0;
            hold     <= '0;
            intrdy_o <= 1'b1;
            in_o     <= '0;
            in_vld_o <= 1'b0;
            rdy_o    <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            in_vld_o <= 1'b0;
            if (start) launched <= 1'b1;
            if (done || timeout) launched <= 1'b0;
            if (out_we_i) shadow <= out_i;
            // A pulse in the launch cycle is newer than what the engine captured.
            if (out_we_i) wr_pend <= 1'b1;
            else if (start && state == ST_XFER_OUT) wr_pend <= 1'b0;
            if (rd_req_i) rd_pend <= 1'b1;
            else if (start && state == ST_XFER_IN && !irq_rd) rd_pend <= 1'b0;

            if (fault) begin
                state <= ST_ERR;
                err_o <= 1'b1;
                rdy_o <= 1'b0;
            end else begin
                case (state)
                    ST_INIT_CFGW: if (done) state <= ST_INIT_CFGR;
                    ST_INIT_CFGR: if (done) state <= ST_INIT_DBNW;
                    ST_INIT_DBNW: if (done) state <= ST_INIT_DBNR;
                    ST_INIT_DBNR: if (done) begin state <= ST_IDLE; rdy_o <= 1'b1; end
                    ST_IDLE: begin
                        if (intrqst_i) begin
                            state  <= ST_XFER_IN;
                            irq_rd <= 1'b1;
                        end else if (wr_pend) begin
                            state  <= ST_XFER_OUT;
                        end else if (rd_pend) begin
                            state  <= ST_XFER_IN;
                            irq_rd <= 1'b0;
                        end
                    end
                    ST_XFER_OUT: if (done) state <= ST_IDLE;
                    ST_XFER_IN: if (done) begin
                        in_o     <= rdata[IOCOUNT-1:0];
                        in_vld_o <= 1'b1;
                        if (irq_rd) begin
                            state    <= ST_INTACK;
                            intrdy_o <= 1'b0;
                            hold     <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    // One low cycle acknowledges; two more keep the stale request masked.
                    ST_INTACK: begin
                        intrdy_o <= 1'b1;
                        hold     <= hold + 2'd1;
                        if (hold == 2'd2) state <= ST_IDLE;
                    end
                    ST_ERR: begin
                        wr_pend <= 1'b0;
                        rd_pend <= 1'b0;
                    end
                    default: state <= ST_ERR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpioctrl.sv
// Directed bench for gpioctrl with a small behavioural GPIO slave attached.
module tb_gpioctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc, stb, we;
    logic [14:0] addr;
    logic [1:0]  sel;
    logic [15:0] dat_o;
    logic        bsy, ack, intrqst, intrdy;
    logic [15:0] dat_i;
    logic [3:0]  out_v = '0;
    logic        out_we = 1'b0, rd_req = 1'b0;
    logic [3:0]  in_v;
    logic        in_vld, rdy, err;

    always #5 clk = ~clk;

    gpioctrl #(.ARCHBITSZ(16), .IOCOUNT(4), .TMASK(4'b0011), .DBNCTHRESH(10),
               .CLKFREQ(1000), .BASEADDR(0), .ACKTO(255)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we),
        .wb_addr_o(addr), .wb_sel_o(sel), .wb_dat_o(dat_o), .wb_bsy_i(bsy),
        .wb_ack_i(ack), .wb_dat_i(dat_i), .intrqst_i(intrqst), .intrdy_o(intrdy),
        .out_i(out_v), .out_we_i(out_we), .rd_req_i(rd_req), .in_o(in_v),
        .in_vld_o(in_vld), .rdy_o(rdy), .err_o(err)
    );

    // Slave controls owned by the stimulus process
    int         sl_iocount = 4;
    logic [3:0] sl_in = '0;
    logic       ack_block = 1'b0, irq_set = 1'b0, bsy_load = 1'b0;

    // Slave state owned by the model process
    logic        p1, irq_flag, intrdy_q;
    logic [15:0] resp, rdat;
    logic [3:0]  sl_o;
    int          bsy_left, log_n, stall_n, vld_n, low_n, fall_n;
    logic [3:0]  vld_val;
    logic        log_we[64];
    logic [14:0] log_addr[64];
    logic [15:0] log_dat[64];
    logic [15:0] rd_val;

    assign bsy     = (bsy_left != 0);
    assign intrqst = irq_flag | irq_set;
    assign dat_i   = rdat;
    assign rd_val  = (addr == 15'd4) ? resp : {12'b0, sl_in};

    always @(posedge clk) begin
        intrdy_q <= intrdy;
        if (irq_set) irq_flag <= 1'b1;
        else if (intrdy_q && !intrdy) irq_flag <= 1'b0;
        if (intrdy_q && !intrdy) fall_n <= log_n;
        if (!intrdy) low_n <= low_n + 1;
        if (in_vld) begin vld_n <= vld_n + 1; vld_val <= in_v; end
        if (bsy_load) bsy_left <= 5;
        else if (cyc && stb && bsy) begin bsy_left <= bsy_left - 1; stall_n <= stall_n + 1; end
        if (!rst_n) begin
            p1  <= 1'b0;
            ack <= 1'b0;
        end else begin
            ack <= p1 && !ack_block;
            p1  <= 1'b0;
            if (cyc && stb && !bsy) begin
                p1 <= 1'b1;
                if (we && addr == 15'd4)
                    resp <= dat_o[15] ? {1'b1, 15'(1000)} : {1'b0, 15'(sl_iocount)};
                else if (we && addr == 15'd0)
                    sl_o <= dat_o[3:0];
                if (!we) rdat <= rd_val;
                if (log_n < 64) begin
                    log_we[log_n]   <= we;
                    log_addr[log_n] <= addr;
                    log_dat[log_n]  <= we ? dat_o : rd_val;
                end
                log_n <= log_n + 1;
            end
        end
    end

    initial begin
        p1 = 0; ack = 0; irq_flag = 0; intrdy_q = 1; resp = '0; rdat = '0; sl_o = '0;
        bsy_left = 0; log_n = 0; stall_n = 0; vld_n = 0; low_n = 0; fall_n = 0; vld_val = '0;
    end

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    function automatic logic [31:0] entry(input int i);
        return {log_we[i], log_addr[i], log_dat[i]};
    endfunction

    int n0, n1, v0, l0, s0, waited;

    initial begin
        // Reset values
        cycles(3);
        check("rst_cyc", {31'b0, cyc}, 0);
        check("rst_stb", {31'b0, stb}, 0);
        check("rst_intrdy", {31'b0, intrdy}, 1);
        check("rst_rdy_err", {30'b0, rdy, err}, 0);
        check("rst_in", {28'b0, in_v}, 0);

        // Boot sequence: first strobe one cycle after release
        n0 = log_n;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_stb", {cyc, stb, we, addr, dat_o}, {3'b111, 15'd4, 16'h0003});
        waited = 0;
        while (!rdy && waited < 100) begin @(negedge clk); waited++; end
        check("boot_rdy", {31'b0, rdy}, 1);
        check("boot_n", log_n - n0, 4);
        check("boot_cfgw", entry(n0),     {1'b1, 15'd4, 16'h0003});
        check("boot_cfgr", entry(n0 + 1), {1'b0, 15'd4, 16'h0004});
        check("boot_dbnw", entry(n0 + 2), {1'b1, 15'd4, 16'h800A});
        check("boot_dbnr", entry(n0 + 3), {1'b0, 15'd4, 16'h83E8});

        // Back-to-back writes coalesce to the latest value
        n0 = log_n;
        out_we = 1'b1; out_v = 4'b0101; @(negedge clk);
        out_v = 4'b0110; @(negedge clk);
        out_we = 1'b0;
        cycles(15);
        check("wr_n", log_n - n0, 1);
        check("wr_txn", entry(n0), {1'b1, 15'd0, 16'h0006});
        check("wr_slave", {28'b0, sl_o}, 4'b0110);

        // Interrupt service
        n0 = log_n; v0 = vld_n; l0 = low_n;
        sl_in = 4'b0100;
        irq_set = 1'b1; @(negedge clk); irq_set = 1'b0;
        cycles(15);
        check("irq_txn", entry(n0), {1'b0, 15'd0, 16'h0004});
        check("irq_in", {28'b0, in_v}, 4'b0100);
        check("irq_vld", vld_n - v0, 1);
        check("irq_low", low_n - l0, 1);
        check("irq_clr", {31'b0, intrqst}, 0);

        // Simultaneous poll and interrupt: interrupt read first
        n0 = log_n; v0 = vld_n;
        sl_in = 4'b1010;
        irq_set = 1'b1; rd_req = 1'b1; @(negedge clk);
        irq_set = 1'b0; rd_req = 1'b0;
        cycles(25);
        check("both_n", log_n - n0, 2);
        check("both_vld", vld_n - v0, 2);
        check("both_order", fall_n - n0, 1);
        check("both_in", {28'b0, vld_val}, 4'b1010);

        // Stall for 5 cycles
        n0 = log_n; s0 = stall_n;
        bsy_load = 1'b1; @(negedge clk); bsy_load = 1'b0;
        out_we = 1'b1; out_v = 4'b1111; @(negedge clk); out_we = 1'b0;
        cycles(20);
        check("bsy_stall", stall_n - s0, 5);
        check("bsy_wr", {28'b0, sl_o}, 4'b1111);
        check("bsy_err", {31'b0, err}, 0);

        // Ack withheld -> timeout, then terminal
        ack_block = 1'b1;
        out_we = 1'b1; out_v = 4'b0001; @(negedge clk); out_we = 1'b0;
        waited = 0;
        while (!err && waited < 400) begin @(negedge clk); waited++; end
        check("to_err", {31'b0, err}, 1);
        check("to_late", {31'b0, waited >= 250}, 1);
        check("to_bus", {30'b0, cyc, rdy}, 0);
        ack_block = 1'b0;
        n1 = log_n;
        out_we = 1'b1; rd_req = 1'b1; @(negedge clk); out_we = 1'b0; rd_req = 1'b0;
        cycles(20);
        check("to_quiet", log_n - n1, 0);

        // Bad IO count at boot
        sl_iocount = 3;
        rst_n = 1'b0; cycles(2);
        check("rst2_err", {31'b0, err}, 0);
        n0 = log_n;
        rst_n = 1'b1;
        cycles(60);
        check("mm_err", {31'b0, err}, 1);
        check("mm_rdy", {31'b0, rdy}, 0);
        check("mm_n", log_n - n0, 2);
        check("mm_bus", {31'b0, cyc}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
